lvdt_sample_ctrl: RTL and testbench

Digital back-end for the LVDT analog macro in the user project area. Periodically asserts the macro's conversion enable, waits a programmable settle time, and captures its 3-bit quantized position code (y2..y0) through a two-flop synchronizer. Averages 2^AVG_LOG2 captures into a position sum and flags full-scale samples. Raises a change interrupt toward user_irq.

---
 rtl/lvdt_sample_ctrl.sv | 140 ++++++++++++++
 tb/tb_lvdt_sample_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvdt_sample_ctrl.sv
// LVDT sampling controller: strobes the conversion enable, waits a settle time,
// captures the synchronized position code and averages 2^AVG_LOG2 captures.
module lvdt_sample_ctrl #(
    parameter int SETTLE   = 4,
    parameter int AVG_LOG2 = 3
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  enable,
    input  logic [15:0]           period,
    input  logic [2:0]            y_in,
    input  logic                  clr_ovr,
    output logic                  lvdt_re,
    output logic [AVG_LOG2+2:0]   pos_sum,
    output logic [2:0]            pos_last,
    output logic                  pos_valid,
    output logic                  overrange,
    output logic                  change_irq
);

    localparam int          SUM_W       = AVG_LOG2 + 3;
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_WAIT
    } state_t;

    state_t              state, next_state;
    logic [2:0]          sync1, sync2;
    logic [15:0]         timer;
    logic [SUM_W-1:0]    acc;
    logic [SUM_W-1:0]    sum_next;
    logic [AVG_LOG2-1:0] cnt;
    logic                have_prev;
    logic                capture;
    logic                last_capture;

    // A capture is abandoned if enable drops in the same cycle.
    assign capture      = (state == ST_CAPTURE) && enable;
    assign last_capture = capture && (&cnt);
    assign sum_next     = acc + SUM_W'(sync2);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of the order the blocks execute in.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= y_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (enable) next_state = ST_STROBE;
            ST_STROBE:  next_state = ST_SETTLE;
            ST_SETTLE:  if (timer == 16'd0) next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_WAIT;
            ST_WAIT:    if (timer == 16'd0) next_state = ST_STROBE;
            default:    next_state = ST_IDLE;
        endcase
        if (!enable) next_state = ST_IDLE;
    end

    // Shared down-counter: loaded on entry to SETTLE or WAIT, then counts to 0.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            timer <= '0;
        end else if (next_state == ST_SETTLE && state != ST_SETTLE) begin
            timer <= SETTLE_LOAD;
        end else if (next_state == ST_WAIT && state != ST_WAIT) begin
            timer <= (period == 16'd0) ? 16'd0 : period - 16'd1;
        end else if (timer != 16'd0) begin
            timer <= timer - 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lvdt_re <= 1'b0;
        end else begin
            lvdt_re <= (next_state == ST_STROBE) || (next_state == ST_SETTLE) ||
                       (next_state == ST_CAPTURE);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            acc        <= '0;
            cnt        <= '0;
            pos_sum    <= '0;
            pos_last   <= '0;
            pos_valid  <= 1'b0;
            change_irq <= 1'b0;
            have_prev  <= 1'b0;
        end else begin
            pos_valid  <= 1'b0;
            change_irq <= 1'b0;
            if (!enable) begin
                acc <= '0;
                cnt <= '0;
            end else if (capture) begin
                pos_last <= sync2;
                if (last_capture) begin
                    pos_sum    <= sum_next;
                    acc        <= '0;
                    cnt        <= '0;
                    pos_valid  <= 1'b1;
                    change_irq <= !have_prev || (sum_next != pos_sum);
                    have_prev  <= 1'b1;
                end else begin
                    acc <= sum_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Set has priority over a coincident clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                         overrange <= 1'b0;
        else if (capture && sync2 == 3'b111)  overrange <= 1'b1;
        else if (clr_ovr)                     overrange <= 1'b0;
    end

endmodule

// File: tb/tb_lvdt_sample_ctrl.sv
// Self-checking bench for lvdt_sample_ctrl: directed scenarios plus randomized
// runs, compared every cycle against a schedule-based reference model.
module tb_lvdt_sample_ctrl;

    localparam int SETTLE   = 4;
    localparam int AVG_LOG2 = 3;
    localparam int NAVG     = 1 << AVG_LOG2;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        enable  = 1'b0;
    logic [15:0] period  = 16'd10;
    logic [2:0]  y_in    = 3'd0;
    logic        clr_ovr = 1'b0;

    logic              lvdt_re;
    logic [AVG_LOG2+2:0] pos_sum;
    logic [2:0]        pos_last;
    logic              pos_valid;
    logic              overrange;
    logic              change_irq;

    lvdt_sample_ctrl #(.SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .enable    (enable),
        .period    (period),
        .y_in      (y_in),
        .clr_ovr   (clr_ovr),
        .lvdt_re   (lvdt_re),
        .pos_sum   (pos_sum),
        .pos_last  (pos_last),
        .pos_valid (pos_valid),
        .overrange (overrange),
        .change_irq(change_irq)
    );

    always #5 clk = ~clk;

    // Reference model: run_t is the cycle index since the run started
    // (1 = strobe cycle); each conversion spans ival cycles.
    int run_t, ival, m_acc, m_n, m_sum, m_last;
    int yh[3];
    bit m_prev, m_ovr, m_re, m_valid, m_irq, m_cap;

    int n_checks, n_errors;
    int cyc, n_valid, n_irq, first_valid;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        run_t = 0; ival = 1; m_acc = 0; m_n = 0; m_sum = 0; m_last = 0;
        for (int i = 0; i < 3; i++) yh[i] = 0;
        m_prev = 0; m_ovr = 0; m_re = 0; m_valid = 0; m_irq = 0; m_cap = 0;
    endtask

    task automatic model_edge();
        bit cap;
        cap = 0;
        m_valid = 0;
        m_irq = 0;
        yh[2] = yh[1];
        yh[1] = yh[0];
        yh[0] = int'(y_in);
        if (!enable) begin
            run_t = 0;
            m_acc = 0;
            m_n = 0;
        end else if (run_t == 0) begin
            run_t = 1;
            ival = ((period == 16'd0) ? 1 : int'(period)) + SETTLE + 2;
        end else begin
            cap = ((run_t - 1) % ival) == SETTLE + 1;
            run_t++;
        end
        m_cap = cap;
        if (cap) begin
            m_last = yh[2];
            m_acc += yh[2];
            m_n++;
            if (m_n == NAVG) begin
                m_irq = !m_prev || (m_acc != m_sum);
                m_sum = m_acc;
                m_valid = 1;
                m_prev = 1;
                m_acc = 0;
                m_n = 0;
            end
        end
        if (cap && yh[2] == 7) m_ovr = 1;
        else if (clr_ovr)      m_ovr = 0;
        m_re = (run_t > 0) && (((run_t - 1) % ival) < SETTLE + 2);
    endtask

    function automatic bit capture_next();
        return enable && (run_t > 0) && (((run_t - 1) % ival) == SETTLE + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        check("lvdt_re",    int'(lvdt_re),    int'(m_re));
        check("pos_valid",  int'(pos_valid),  int'(m_valid));
        check("change_irq", int'(change_irq), int'(m_irq));
        check("pos_sum",    int'(pos_sum),    m_sum);
        check("pos_last",   int'(pos_last),   m_last);
        check("overrange",  int'(overrange),  int'(m_ovr));
        if (pos_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (change_irq) n_irq++;
    endtask

    task automatic run(input int n, input bit rand_y, input bit rand_clr);
        for (int i = 0; i < n; i++) begin
            tick();
            if (rand_y && m_cap) y_in = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            clr_ovr = rand_clr && ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic wait_cap(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_cap && k < 200);
        check(tag, int'(m_cap), 1);
    endtask

    task automatic wait_cap_next(input string tag);
        int k;
        k = 0;
        while (!capture_next() && k < 200) begin
            tick();
            k++;
        end
        check(tag, int'(capture_next()), 1);
    endtask

    task automatic wait_phase(input string tag, input int u);
        int k;
        k = 0;
        while (!(run_t > 0 && ((run_t - 1) % ival) == u) && k < 200) begin
            tick();
            k++;
        end
        check(tag, int'(run_t > 0 && ((run_t - 1) % ival) == u), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_re"},    int'(lvdt_re),    0);
        check({tag, "_sum"},   int'(pos_sum),    0);
        check({tag, "_last"},  int'(pos_last),   0);
        check({tag, "_valid"}, int'(pos_valid),  0);
        check({tag, "_ovr"},   int'(overrange),  0);
        check({tag, "_irq"},   int'(change_irq), 0);
    endtask

    initial begin
        int ncap, k, rise0, rise1;
        bit prev_re;
        n_checks = 0; n_errors = 0; cyc = 0; n_valid = 0; n_irq = 0; first_valid = -1;
        model_reset();

        // Reset state, released between edges.
        #12;
        check_all_zero("reset");
        rst = 1'b0;

        // Strobe timing and averaging with a constant code of 5.
        period = 16'd10;
        y_in   = 3'b101;
        enable = 1'b1;
        cyc    = 0;
        run(2 * NAVG * 16 + 4, 1'b0, 1'b0);
        check("avg_first_valid_cycle", first_valid, 119);
        check("avg_sum",   int'(pos_sum),  40);
        check("avg_last",  int'(pos_last), 5);
        check("avg_valids", n_valid, 2);
        check("avg_irqs",   n_irq,   1);

        // Overrange: one 111 capture, then 010; sticky until cleared.
        wait_cap("ovr_align");
        y_in = 3'b111;
        wait_cap("ovr_cap111");
        y_in = 3'b010;
        check("ovr_set", int'(overrange), 1);
        run(20, 1'b0, 1'b0);
        check("ovr_sticky", int'(overrange), 1);
        wait_phase("ovr_idle_phase", 3);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ovr_cleared", int'(overrange), 0);
        // Set wins over a coincident clear.
        wait_cap("ovr_align2");
        y_in = 3'b111;
        wait_cap_next("ovr_capnext");
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        y_in = 3'b010;
        check("ovr_set_wins", int'(overrange), 1);
        run(3, 1'b0, 1'b0);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ovr_lone_clear", int'(overrange), 0);

        // Disable mid-average after 5 captures, during SETTLE.
        k = 0;
        while (!pos_valid && k < 300) begin
            run(1, 1'b1, 1'b0);
            k++;
        end
        check("dis_group_aligned", int'(pos_valid), 1);
        for (int i = 0; i < 5; i++) begin
            wait_cap("dis_cap");
            y_in = 3'($urandom_range(0, 6));
        end
        wait_phase("dis_settle", 2);
        enable = 1'b0;
        tick();
        check("dis_re_drop", int'(lvdt_re), 0);
        run(5, 1'b0, 1'b0);
        enable = 1'b1;
        ncap = 0;
        k = 0;
        do begin
            run(1, 1'b1, 1'b0);
            if (m_cap) ncap++;
            k++;
        end while (!pos_valid && k < 400);
        check("dis_fresh_caps", ncap, NAVG);

        // Async reset pulsed between edges in the middle of SETTLE.
        wait_phase("rst_settle", 2);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #1;
        rst = 1'b0;
        cyc = 0;
        tick();
        check("rst_restart_strobe", int'(lvdt_re), 1);
        run(40, 1'b1, 1'b0);

        // period = 0 behaves as 1: strobes every SETTLE+3 cycles.
        enable = 1'b0;
        run(2, 1'b0, 1'b0);
        period = 16'd0;
        enable = 1'b1;
        rise0 = -1; rise1 = -1;
        prev_re = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            run(1, 1'b1, 1'b0);
            if (lvdt_re && !prev_re) begin
                if (rise0 < 0) rise0 = cyc;
                else if (rise1 < 0) rise1 = cyc;
            end
            prev_re = lvdt_re;
        end
        check("p0_interval", rise1 - rise0, SETTLE + 3);

        // Randomized runs: random period, codes, clears and restarts.
        for (int r = 0; r < 6; r++) begin
            enable = 1'b0;
            run($urandom_range(1, 4), 1'b0, 1'b1);
            period = 16'($urandom_range(0, 12));
            enable = 1'b1;
            run($urandom_range(200, 500), 1'b1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
